// File: rtl/psram_core_arbiter.sv
// rtl/psram_core_arbiter.sv - two-port arbiter sharing one PSRAM controller core
// Define PSRAM_ARB_ROUND_ROBIN_EN for round-robin tie-break; otherwise port 0 has fixed priority.
module psram_core_arbiter #(
  parameter int AW = 24
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  input  logic [31:0]   m0_wdata,
  input  logic [2:0]    m0_size,
  input  logic          m0_rd_wr,
  output logic          m0_ack,
  output logic [31:0]   m0_rdata,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  input  logic [31:0]   m1_wdata,
  input  logic [2:0]    m1_size,
  input  logic          m1_rd_wr,
  output logic          m1_ack,
  output logic [31:0]   m1_rdata,
  output logic          core_start,
  output logic [AW-1:0] core_addr,
  output logic [31:0]   core_data_i,
  output logic [2:0]    core_size,
  output logic          core_rd_wr,
  input  logic          core_done,
  input  logic [31:0]   core_data_o,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t        state_q;
  logic          owner_q;
  logic [AW-1:0] core_addr_q;
  logic [31:0]   core_wdata_q;
  logic [2:0]    core_size_q;
  logic          core_rd_wr_q;
  logic [31:0]   m0_rdata_q;
  logic [31:0]   m1_rdata_q;
  logic          grant_d;
  logic          any_req;

`ifdef PSRAM_ARB_ROUND_ROBIN_EN
  // Tie-break history; resets to port 1 so the first tie after reset goes to port 0.
  logic          last_q;

  always_comb begin
    any_req = m0_req | m1_req;
    grant_d = (m0_req & m1_req) ? ~last_q : m1_req;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      last_q <= 1'b1;
    end else if (state_q == S_IDLE && any_req) begin
      last_q <= grant_d;
    end
  end
`else
  always_comb begin
    any_req = m0_req | m1_req;
    grant_d = ~m0_req & m1_req;
  end
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      core_addr_q  <= '0;
      core_wdata_q <= '0;
      core_size_q  <= '0;
      core_rd_wr_q <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            owner_q      <= grant_d;
            core_addr_q  <= grant_d ? m1_addr  : m0_addr;
            core_wdata_q <= grant_d ? m1_wdata : m0_wdata;
            core_size_q  <= grant_d ? m1_size  : m0_size;
            core_rd_wr_q <= grant_d ? m1_rd_wr : m0_rd_wr;
            state_q      <= S_ISSUE;
          end
        end
        S_ISSUE: state_q <= S_WAIT;
        S_WAIT: begin
          if (core_done) begin
            // Writes complete with an ack but leave the read-data holding register alone.
            if (core_rd_wr_q) begin
              if (owner_q) m1_rdata_q <= core_data_o;
              else         m0_rdata_q <= core_data_o;
            end
            state_q <= S_RESP;
          end
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign core_start  = (state_q == S_ISSUE);
  assign busy        = (state_q != S_IDLE);
  assign owner       = owner_q;
  assign m0_ack      = (state_q == S_RESP) && !owner_q;
  assign m1_ack      = (state_q == S_RESP) &&  owner_q;
  assign m0_rdata    = m0_rdata_q;
  assign m1_rdata    = m1_rdata_q;
  assign core_addr   = core_addr_q;
  assign core_data_i = core_wdata_q;
  assign core_size   = core_size_q;
  assign core_rd_wr  = core_rd_wr_q;

endmodule

// File: tb/tb_psram_core_arbiter.sv
// tb/tb_psram_core_arbiter.sv - directed self-checking bench for psram_core_arbiter
// Tie-break expectations follow PSRAM_ARB_ROUND_ROBIN_EN when defined.
module tb_psram_core_arbiter;
  localparam int AW = 24;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic          m0_req, m1_req;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [31:0]   m0_wdata, m1_wdata;
  logic [2:0]    m0_size, m1_size;
  logic          m0_rd_wr, m1_rd_wr;
  logic          m0_ack, m1_ack;
  logic [31:0]   m0_rdata, m1_rdata;
  logic          core_start;
  logic [AW-1:0] core_addr;
  logic [31:0]   core_data_i;
  logic [2:0]    core_size;
  logic          core_rd_wr;
  logic          core_done;
  logic [31:0]   core_data_o;
  logic          busy, owner;

  int checks = 0;
  int failures = 0;

  psram_core_arbiter #(.AW(AW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_size(m0_size),
    .m0_rd_wr(m0_rd_wr), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_size(m1_size),
    .m1_rd_wr(m1_rd_wr), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .core_start(core_start), .core_addr(core_addr), .core_data_i(core_data_i),
    .core_size(core_size), .core_rd_wr(core_rd_wr), .core_done(core_done),
    .core_data_o(core_data_o), .busy(busy), .owner(owner)
  );

  always #5 HCLK = ~HCLK;

  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " owner"}, 32'(owner), 32'd0);
    chk({tag, " core_start"}, 32'(core_start), 32'd0);
    chk({tag, " core_addr"}, 32'(core_addr), 32'd0);
    chk({tag, " core_data_i"}, core_data_i, 32'd0);
    chk({tag, " core_size"}, 32'(core_size), 32'd0);
    chk({tag, " core_rd_wr"}, 32'(core_rd_wr), 32'd0);
    chk({tag, " m0_ack"}, 32'(m0_ack), 32'd0);
    chk({tag, " m1_ack"}, 32'(m1_ack), 32'd0);
    chk({tag, " m0_rdata"}, m0_rdata, 32'd0);
    chk({tag, " m1_rdata"}, m1_rdata, 32'd0);
  endtask

  logic exp_own [4];

  initial begin
    HRESETn = 1'b0;
    m0_req = 0; m0_addr = '0; m0_wdata = '0; m0_size = '0; m0_rd_wr = 0;
    m1_req = 0; m1_addr = '0; m1_wdata = '0; m1_size = '0; m1_rd_wr = 0;
    core_done = 0; core_data_o = '0;
    cyc(); cyc();
    chk_reset_vals("rst");
    HRESETn = 1'b1;
    cyc();

    // Single read on port 0, core_done five cycles after core_start
    m0_req = 1; m0_addr = 24'h000100; m0_size = 3'd4; m0_rd_wr = 1;
    cyc();
    chk("rd0 start", 32'(core_start), 32'd1);
    chk("rd0 busy", 32'(busy), 32'd1);
    chk("rd0 owner", 32'(owner), 32'd0);
    chk("rd0 addr", 32'(core_addr), 32'h000100);
    chk("rd0 size", 32'(core_size), 32'd4);
    chk("rd0 dir", 32'(core_rd_wr), 32'd1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("rd0 wait start", 32'(core_start), 32'd0);
      chk("rd0 wait ack", 32'(m0_ack), 32'd0);
    end
    core_done = 1; core_data_o = 32'hDEADBEEF;
    cyc();
    core_done = 0;
    chk("rd0 ack", 32'(m0_ack), 32'd1);
    chk("rd0 m1_ack", 32'(m1_ack), 32'd0);
    chk("rd0 rdata", m0_rdata, 32'hDEADBEEF);
    m0_req = 0;
    cyc();
    chk("rd0 ack end", 32'(m0_ack), 32'd0);
    chk("rd0 idle", 32'(busy), 32'd0);
    chk("rd0 hold", m0_rdata, 32'hDEADBEEF);

    // Single write on port 1
    m1_req = 1; m1_addr = 24'h7FFFFC; m1_wdata = 32'h12345678; m1_size = 3'd2; m1_rd_wr = 0;
    cyc();
    chk("wr1 start", 32'(core_start), 32'd1);
    chk("wr1 owner", 32'(owner), 32'd1);
    chk("wr1 addr", 32'(core_addr), 32'h7FFFFC);
    chk("wr1 data", core_data_i, 32'h12345678);
    chk("wr1 size", 32'(core_size), 32'd2);
    chk("wr1 dir", 32'(core_rd_wr), 32'd0);
    cyc();
    core_done = 1; core_data_o = 32'hCAFEF00D;
    cyc();
    core_done = 0;
    chk("wr1 ack", 32'(m1_ack), 32'd1);
    chk("wr1 m0_ack", 32'(m0_ack), 32'd0);
    chk("wr1 rdata", m1_rdata, 32'd0);
    m1_req = 0;
    cyc();

    // Port 1 request arrives while port 0 is waiting on the core
    m0_req = 1; m0_addr = 24'h000200; m0_rd_wr = 1; m0_size = 3'd4;
    cyc();
    chk("ovl issue0 owner", 32'(owner), 32'd0);
    cyc();
    m1_req = 1; m1_addr = 24'h000300; m1_rd_wr = 1; m1_size = 3'd1;
    cyc();
    chk("ovl wait owner", 32'(owner), 32'd0);
    chk("ovl wait start", 32'(core_start), 32'd0);
    core_done = 1; core_data_o = 32'h11112222;
    cyc();
    core_done = 0;
    chk("ovl m0_ack", 32'(m0_ack), 32'd1);
    chk("ovl m1_ack early", 32'(m1_ack), 32'd0);
    chk("ovl m0_rdata", m0_rdata, 32'h11112222);
    m0_req = 0;
    cyc();
    chk("ovl gap busy", 32'(busy), 32'd0);
    chk("ovl gap start", 32'(core_start), 32'd0);
    cyc();
    chk("ovl issue1 start", 32'(core_start), 32'd1);
    chk("ovl issue1 owner", 32'(owner), 32'd1);
    chk("ovl issue1 addr", 32'(core_addr), 32'h000300);
    chk("ovl issue1 size", 32'(core_size), 32'd1);
    cyc();
    core_done = 1; core_data_o = 32'h33334444;
    cyc();
    core_done = 0;
    chk("ovl m1_ack", 32'(m1_ack), 32'd1);
    chk("ovl m1_rdata", m1_rdata, 32'h33334444);
    chk("ovl m0_rdata hold", m0_rdata, 32'h11112222);
    m1_req = 0;
    cyc();

    // Spurious core_done in IDLE and a repeated one in RESP
    core_done = 1; core_data_o = 32'hFFFFFFFF;
    cyc();
    core_done = 0;
    chk("spur idle busy", 32'(busy), 32'd0);
    chk("spur idle ack0", 32'(m0_ack), 32'd0);
    chk("spur idle ack1", 32'(m1_ack), 32'd0);
    chk("spur idle rdata", m0_rdata, 32'h11112222);
    m0_req = 1; m0_addr = 24'h000400; m0_rd_wr = 1;
    cyc(); cyc();
    core_done = 1; core_data_o = 32'h55556666;
    cyc();
    chk("spur resp ack", 32'(m0_ack), 32'd1);
    chk("spur resp rdata", m0_rdata, 32'h55556666);
    core_data_o = 32'h77778888;
    m0_req = 0;
    cyc();
    core_done = 0;
    chk("spur after ack0", 32'(m0_ack), 32'd0);
    chk("spur after busy", 32'(busy), 32'd0);
    chk("spur after rdata", m0_rdata, 32'h55556666);
    cyc();
    chk("spur later ack0", 32'(m0_ack), 32'd0);
    chk("spur later busy", 32'(busy), 32'd0);

    // Reset asserted during WAIT
    m0_req = 1; m0_addr = 24'h000500; m0_rd_wr = 1;
    cyc(); cyc();
    chk("mrst pre busy", 32'(busy), 32'd1);
    HRESETn = 1'b0;
    #1;
    chk_reset_vals("mrst");
    m0_req = 0;
    cyc();
    HRESETn = 1'b1;
    cyc();
    chk("mrst post ack0", 32'(m0_ack), 32'd0);
    chk("mrst post busy", 32'(busy), 32'd0);
    m0_req = 1; m0_addr = 24'h000600; m0_rd_wr = 1; m0_size = 3'd4;
    cyc();
    chk("mrst fresh start", 32'(core_start), 32'd1);
    chk("mrst fresh addr", 32'(core_addr), 32'h000600);
    cyc();
    core_done = 1; core_data_o = 32'h9999AAAA;
    cyc();
    core_done = 0;
    chk("mrst fresh ack", 32'(m0_ack), 32'd1);
    chk("mrst fresh rdata", m0_rdata, 32'h9999AAAA);
    m0_req = 0;
    cyc();

    // Tie from reset with both ports requesting continuously
`ifdef PSRAM_ARB_ROUND_ROBIN_EN
    exp_own[0] = 0; exp_own[1] = 1; exp_own[2] = 0; exp_own[3] = 1;
`else
    exp_own[0] = 0; exp_own[1] = 0; exp_own[2] = 0; exp_own[3] = 0;
`endif
    HRESETn = 1'b0;
    cyc();
    HRESETn = 1'b1;
    m0_req = 1; m0_addr = 24'h000A00; m0_rd_wr = 1;
    m1_req = 1; m1_addr = 24'h000B00; m1_rd_wr = 1;
    for (int t = 0; t < 4; t++) begin
      cyc();
      chk($sformatf("tie%0d start", t), 32'(core_start), 32'd1);
      chk($sformatf("tie%0d owner", t), 32'(owner), 32'(exp_own[t]));
      chk($sformatf("tie%0d addr", t), 32'(core_addr), exp_own[t] ? 32'h000B00 : 32'h000A00);
      cyc();
      core_done = 1; core_data_o = 32'h0 + t;
      cyc();
      core_done = 0;
      chk($sformatf("tie%0d m0_ack", t), 32'(m0_ack), 32'(!exp_own[t]));
      chk($sformatf("tie%0d m1_ack", t), 32'(m1_ack), 32'(exp_own[t]));
      cyc();
      chk($sformatf("tie%0d gap", t), 32'(busy), 32'd0);
    end
    m0_req = 0; m1_req = 0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/psram_core_arbiter.md
# psram_core_arbiter

Two-port arbiter that shares one PSRAM controller core (start/done handshake, 24-bit address, 32-bit write/read data, 1/2/4-byte size) between two independent requesters. Typical pairing: port 0 = AHB-Lite data wrapper, port 1 = instruction cache or DMA refill engine. The block latches the winner's request, drives the core, returns read data and a one-cycle acknowledge, and owns the core for exactly one transfer per grant.

## Interface
Parameters:
- AW, 24, address width presented to the core.

Ports:
- HCLK  in  1  single clock for all logic.
- HRESETn  in  1  asynchronous, active-low reset.
- m0_req / m1_req  in  1  level request; held until matching ack.
- m0_addr / m1_addr  in  AW  byte address.
- m0_wdata / m1_wdata  in  32  write data.
- m0_size / m1_size  in  3  byte count: 1, 2 or 4.
- m0_rd_wr / m1_rd_wr  in  1  1 = read, 0 = write.
- m0_ack / m1_ack  out  1  one-cycle completion pulse.
- m0_rdata / m1_rdata  out  32  read data; valid while the matching ack is high, then held.
- core_start  out  1  one-cycle start pulse to the core.
- core_addr  out  AW  latched address.
- core_data_i  out  32  latched write data.
- core_size  out  3  latched size.
- core_rd_wr  out  1  latched direction.
- core_done  in  1  one-cycle completion pulse from the core.
- core_data_o  in  32  core read data, valid when core_done = 1.
- busy  out  1  high in every state other than IDLE.
- owner  out  1  port that holds or last held the core.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req is high, select the winner, latch its addr/wdata/size/rd_wr into core_* registers, set owner, go to ISSUE. If no req, stay.
- ISSUE: core_start = 1 for this one cycle; go to WAIT.
- WAIT: on core_done = 1, capture core_data_o into the owner's rdata register, go to RESP. core_done is ignored in every other state.
- RESP: owner's ack = 1 for this one cycle; go to IDLE.
- Requester rule: deassert req on the edge at which ack is sampled high; change addr/wdata/size/rd_wr only while req is low or after ack. A req still high in the IDLE cycle after its own ack is a new request.
- A req on the non-owner port during ISSUE/WAIT/RESP waits; it is not lost.
- Writes also receive ack; rdata of a write is don't-care but the rdata register is not updated by writes.
- Arbitration on a simultaneous req is set by the configuration below. A single requester always wins immediately.

## Timing
- Reset values: state IDLE, core_start 0, core_addr 0, core_data_i 0, core_size 0, core_rd_wr 0, m0_ack 0, m1_ack 0, m0_rdata 0, m1_rdata 0, busy 0, owner 0 (last-owner history = port 1).
- All outputs are registered or decoded from state and registers only; no combinational path from any input to any output.
- Latency: req sampled high in IDLE at edge N -> core_start high in cycle N+1 -> WAIT from N+2 -> core_done at cycle D -> ack in cycle D+1 -> IDLE at D+2. Minimum req-to-ack is 3 cycles when core_done arrives in the first WAIT cycle.
- Back-to-back: the next grant is sampled in the IDLE cycle after RESP, so there is a 1-cycle gap between transfers.
- Asserting reset mid-transfer returns the block to IDLE immediately and drops any pending ack. The core shares HRESETn, so there is no orphaned transfer.

## Configuration
- PSRAM_ARB_ROUND_ROBIN_EN defined: on simultaneous req, grant goes to the port that is not owner. Owner is updated on each grant, so two continuously requesting ports alternate 0,1,0,1.
- Not defined: fixed priority. Port 0 always wins a tie, and port 1 can starve under continuous port-0 traffic.

## Test plan
- Single read, port 0: addr 0x000100, size 4, core_done 5 cycles after core_start, core_data_o 0xDEADBEEF -> core_start once; m0_ack one cycle later; m0_rdata = 0xDEADBEEF; m1_ack never set.
- Single write, port 1: addr 0x7FFFFC, wdata 0x12345678, size 2 -> core_addr = 0x7FFFFC, core_data_i = 0x12345678, core_size = 2, core_rd_wr = 0; m1_ack pulses; m1_rdata unchanged.
- Tie from reset, both req high continuously for 4 transfers -> with PSRAM_ARB_ROUND_ROBIN_EN the owner sequence is 0,1,0,1; without it the sequence is 0,0,0,0 and m1_ack never appears.
- Port 1 req raised during port 0 WAIT -> port 0 completes first; port 1 is granted in the IDLE cycle after m0_ack, with exactly 1 idle cycle between transfers.
- Spurious core_done in IDLE and a second core_done in RESP -> no state change, no extra ack, rdata unchanged.
- HRESETn low during WAIT, then released -> all outputs at reset values, no ack. A fresh port 0 req then completes normally.
